exec_stage: RTL and testbench
=============================

Name: exec_stage

Overview:
- Execute stage sitting directly upstream of the register file's write port.
- Consumes the two register-file read operands (regA/regB) plus an opcode and destination address.
- Computes an 8-bit result and flag, then drives the register file's write-back inputs (enableWrite, registerWrite, dataIn, flag).
- Single-cycle ALU ops; MUL is an iterative shift-add taking WIDTH cycles, with a ready/valid handshake toward the decode/issue logic.

Parameters:
- WIDTH, 8, data width of operands and result
- ADDR_W, 3, register address width (8 registers)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation request valid
- in_ready  output  1  stage can accept; high only in IDLE
- op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 MUL
- regA  input  WIDTH  operand A from register file
- regB  input  WIDTH  operand B from register file
- dest  input  ADDR_W  destination register
- enableWrite  output  1  one-cycle write-back strobe to register file
- registerWrite  output  ADDR_W  write-back address
- dataIn  output  WIDTH  write-back data
- flag  output  1  result flag, valid with enableWrite
- busy  output  1  MUL in progress (inverse of in_ready)

Behaviour:
- Reset (async, immediate):
  - state=IDLE; enableWrite, registerWrite, dataIn, flag, busy all 0; in_ready=1.
  - Iteration counter and operand registers cleared.
- Accept: on the rising edge where in_valid && in_ready. in_valid while in_ready=0 is ignored; no queuing.
- Single-cycle ops (IDLE, op≠111):
  - At the accept edge, register dataIn, flag and registerWrite=dest, and set enableWrite=1.
  - enableWrite is high for exactly the following cycle, then returns to 0 unless a new op is accepted.
  - Back-to-back accepts on consecutive edges are allowed; enableWrite stays high continuously.
- Arithmetic, all truncated to WIDTH:
  - ADD: A+B; flag = carry out.
  - SUB: A-B; flag = borrow (A<B unsigned).
  - AND/OR/XOR: bitwise; flag = (result==0).
  - SLL/SRL: shift A by B[2:0]; flag = last bit shifted out, 0 when shift amount is 0.
- MUL FSM, states IDLE and MUL:
  - Accept edge k:
    - Latch A (multiplicand), B (multiplier) and dest.
    - Set accumulator=0, cnt=0, state=MUL.
    - Drive enableWrite=0 for the next cycle.
  - Edges k+1..k+WIDTH, one shift-add step each:
    - If multiplier LSB is 1, add shifted multiplicand into a 2*WIDTH-bit accumulator.
    - Shift multiplicand left and multiplier right; cnt++.
  - Edge k+WIDTH (cnt==WIDTH-1 step):
    - Register dataIn = acc[WIDTH-1:0] and flag = (acc[2*WIDTH-1:WIDTH]≠0), i.e. overflow.
    - Set registerWrite=dest, enableWrite=1, state=IDLE.
  - in_ready=0 and busy=1 from after edge k through edge k+WIDTH. Earliest next accept is edge k+WIDTH+1.
  - Latency: enableWrite high in the cycle after edge k+WIDTH (WIDTH+1 cycles after accept).
- Operands are sampled only at the accept edge. regA/regB/dest changes during MUL have no effect.
- Reset during MUL aborts the operation: no write-back is ever issued for it, and the stage returns to IDLE.
- dest=0 is written like any other register; no special case.

Optional Feature:
- Macro EXEC_MUL_EN.
- Defined: op 111 is the iterative MUL described above, and busy can assert.
- Undefined:
  - No MUL datapath or counter is built.
  - op 111 is MOV: single-cycle, dataIn=B, flag=(B==0).
  - in_ready is tied to 1 and busy to 0.

Test Plan:
- Reset, then ADD A=0xCA B=0x56 dest=1 -> next cycle enableWrite=1, registerWrite=1, dataIn=0x20, flag=1; following cycle enableWrite=0.
- Back-to-back SUB A=0x05 B=0x07 dest=4, then XOR A=0x3C B=0x3C dest=2 -> cycle 1: dataIn=0xFE, flag=1, addr 4; cycle 2: dataIn=0x00, flag=1, addr 2; enableWrite high both cycles.
- SLL A=0x81 B=0x01 -> dataIn=0x02, flag=1; SRL A=0x81 B=0x00 -> dataIn=0x81, flag=0.
- MUL A=0x0D B=0x0B dest=3 (EXEC_MUL_EN) -> in_ready low 8 cycles, ADD request during busy ignored; enableWrite high 9 cycles after accept with dataIn=0x8F, flag=0. MUL 0x20*0x10 -> dataIn=0x00, flag=1.
- Reset asserted asynchronously mid-MUL (4th iteration) -> all outputs 0 immediately, in_ready=1 after release, no enableWrite pulse for the aborted op.
- Without EXEC_MUL_EN: op 111 B=0x5A -> next cycle dataIn=0x5A, flag=0, in_ready stays 1.

Source files
------------

// File: rtl/exec_stage.sv
// exec_stage: execute stage feeding the register file write-back port.
// Single-cycle ALU ops (ADD/SUB/AND/OR/XOR/SLL/SRL) plus, when the
// EXEC_MUL_EN macro is defined, an iterative shift-add MUL on op 111.
// With EXEC_MUL_EN undefined, op 111 is a single-cycle MOV of operand B.
module exec_stage #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  regA,
  input  logic [WIDTH-1:0]  regB,
  input  logic [ADDR_W-1:0] dest,
  output logic              enableWrite,
  output logic [ADDR_W-1:0] registerWrite,
  output logic [WIDTH-1:0]  dataIn,
  output logic              flag,
  output logic              busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;

  logic              en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  data_q;
  logic              flag_q;

  logic [WIDTH-1:0]  alu_res;
  logic              alu_flag;
  logic [WIDTH:0]    sum_w;
  logic [WIDTH:0]    dif_w;
  logic [WIDTH:0]    sll_w;
  logic [WIDTH:0]    srl_w;
  logic [2:0]        sh;

  // Single-cycle ALU: one extra bit on each path captures carry/borrow/shifted-out bit
  always_comb begin
    sh    = regB[2:0];
    sum_w = {1'b0, regA} + {1'b0, regB};
    dif_w = {1'b0, regA} - {1'b0, regB};
    sll_w = {1'b0, regA} << sh;
    srl_w = {regA, 1'b0} >> sh;
    alu_res  = '0;
    alu_flag = 1'b0;
    case (op)
      OP_ADD: begin alu_res = sum_w[WIDTH-1:0]; alu_flag = sum_w[WIDTH]; end
      OP_SUB: begin alu_res = dif_w[WIDTH-1:0]; alu_flag = dif_w[WIDTH]; end
      OP_AND: begin alu_res = regA & regB; alu_flag = ~|(regA & regB); end
      OP_OR:  begin alu_res = regA | regB; alu_flag = ~|(regA | regB); end
      OP_XOR: begin alu_res = regA ^ regB; alu_flag = ~|(regA ^ regB); end
      OP_SLL: begin alu_res = sll_w[WIDTH-1:0]; alu_flag = sll_w[WIDTH]; end
      OP_SRL: begin alu_res = srl_w[WIDTH:1]; alu_flag = srl_w[0]; end
      default: begin alu_res = regB; alu_flag = ~|regB; end
    endcase
  end

`ifdef EXEC_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam int         CNT_W  = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t              state_q;
  logic [2*WIDTH-1:0]  mcand_q;
  logic [2*WIDTH-1:0]  acc_q;
  logic [2*WIDTH-1:0]  acc_step;
  logic [WIDTH-1:0]    mplier_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   dest_q;

  // One shift-add partial product per MUL cycle
  always_comb begin
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  // Accept/issue FSM; write-back registers are driven from both states
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      flag_q   <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      dest_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          en_q <= 1'b0;
          if (in_valid) begin
            if (op == OP_MUL) begin
              mcand_q  <= {{WIDTH{1'b0}}, regA};
              mplier_q <= regB;
              dest_q   <= dest;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= S_MUL;
            end else begin
              en_q   <= 1'b1;
              addr_q <= dest;
              data_q <= alu_res;
              flag_q <= alu_flag;
            end
          end
        end
        S_MUL: begin
          en_q     <= 1'b0;
          acc_q    <= acc_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            data_q  <= acc_step[WIDTH-1:0];
            flag_q  <= |acc_step[2*WIDTH-1:WIDTH];
            addr_q  <= dest_q;
            en_q    <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q == S_MUL);
`else
  // Every accepted op completes in one cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      flag_q <= 1'b0;
    end else begin
      en_q <= in_valid;
      if (in_valid) begin
        addr_q <= dest;
        data_q <= alu_res;
        flag_q <= alu_flag;
      end
    end
  end

  assign in_ready = 1'b1;
  assign busy     = 1'b0;
`endif

  assign enableWrite   = en_q;
  assign registerWrite = addr_q;
  assign dataIn        = data_q;
  assign flag          = flag_q;

endmodule

// File: tb/tb_exec_stage.sv
// Testbench for exec_stage: scoreboard of expected write-backs, one task per scenario.
module tb_exec_stage;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = 3'd0;
  logic [7:0] regA = 8'd0;
  logic [7:0] regB = 8'd0;
  logic [2:0] dest = 3'd0;
  logic       enableWrite;
  logic [2:0] registerWrite;
  logic [7:0] dataIn;
  logic       flag;
  logic       busy;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
    logic       flg;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  wb_seen = 0;

  exec_stage #(.WIDTH(8), .ADDR_W(3)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .regA(regA), .regB(regB), .dest(dest),
    .enableWrite(enableWrite), .registerWrite(registerWrite),
    .dataIn(dataIn), .flag(flag), .busy(busy)
  );

  always #5 clock = ~clock;

  // Independent reference model: returns {flag, data}
  function automatic logic [8:0] model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int unsigned s;
    logic [7:0]  r;
    logic        f;
    logic [15:0] p;
    r = 8'd0; f = 1'b0;
    case (o)
      3'd0: begin s = a + b; r = s[7:0]; f = (s > 255); end
      3'd1: begin r = a - b; f = (a < b); end
      3'd2: begin r = a & b; f = (r == 8'd0); end
      3'd3: begin r = a | b; f = (r == 8'd0); end
      3'd4: begin r = a ^ b; f = (r == 8'd0); end
      3'd5: begin r = a; for (int i = 0; i < int'(b[2:0]); i++) begin f = r[7]; r = r << 1; end end
      3'd6: begin r = a; for (int i = 0; i < int'(b[2:0]); i++) begin f = r[0]; r = r >> 1; end end
      default: begin
`ifdef EXEC_MUL_EN
        p = a * b; r = p[7:0]; f = (p[15:8] != 8'd0);
`else
        p = 16'd0; r = b; f = (b == 8'd0);
`endif
      end
    endcase
    return {f, r};
  endfunction

  // Scoreboard: every write-back strobe must match the oldest expected entry
  always @(posedge clock) begin
    #1;
    if (!reset && enableWrite) begin
      wb_t e;
      wb_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected addr=%0d data=%02h flag=%0b required=none", registerWrite, dataIn, flag);
      end else begin
        e = exp_q.pop_front();
        if ({registerWrite, dataIn, flag} !== {e.addr, e.data, e.flg}) begin
          failures++;
          $display("FAIL wb_data got addr=%0d data=%02h flag=%0b required addr=%0d data=%02h flag=%0b",
                   registerWrite, dataIn, flag, e.addr, e.data, e.flg);
        end else
          $display("wb addr=%0d data=%02h flag=%0b ok", registerWrite, dataIn, flag);
      end
    end
  end

  // Present a request on the next negedge; returns right after the following posedge
  task automatic send(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
    @(negedge clock);
    in_valid = 1'b1; op = o; regA = a; regB = b; dest = d;
    @(posedge clock);
  endtask

  task automatic push(input logic [2:0] d, input logic [7:0] data, input logic f);
    wb_t e;
    e.addr = d; e.data = data; e.flg = f;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({enableWrite, registerWrite, dataIn, flag, busy, in_ready} !== {1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state got en=%0b addr=%0d data=%02h flag=%0b busy=%0b rdy=%0b required 0/0/00/0/0/1",
               enableWrite, registerWrite, dataIn, flag, busy, in_ready);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_add();
    send(3'd0, 8'hCA, 8'h56, 3'd1);
    push(3'd1, 8'h20, 1'b1);
    @(negedge clock); in_valid = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (enableWrite !== 1'b0) begin
      failures++;
      $display("FAIL add_strobe_end got en=%0b required 0", enableWrite);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    send(3'd1, 8'h05, 8'h07, 3'd4); push(3'd4, 8'hFE, 1'b1);
    send(3'd4, 8'h3C, 8'h3C, 3'd2); push(3'd2, 8'h00, 1'b1);
    #1;
    checks++;
    if (enableWrite !== 1'b1) begin
      failures++;
      $display("FAIL b2b_strobe got en=%0b required 1", enableWrite);
    end
    idle(2);
  endtask

  task automatic test_shift();
    send(3'd5, 8'h81, 8'h01, 3'd5); push(3'd5, 8'h02, 1'b1);
    send(3'd6, 8'h81, 8'h00, 3'd6); push(3'd6, 8'h81, 1'b0);
    send(3'd6, 8'h81, 8'h03, 3'd0); push(3'd0, 8'h10, 1'b0);
    send(3'd5, 8'h3F, 8'h07, 3'd7); push(3'd7, 8'h80, 1'b1);
    idle(2);
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [7:0] a, b;
    logic [2:0] d;
    logic [8:0] m;
    for (int i = 0; i < 40; i++) begin
`ifdef EXEC_MUL_EN
      o = 3'($urandom_range(0, 6));
`else
      o = 3'($urandom_range(0, 7));
`endif
      a = 8'($urandom); b = 8'($urandom); d = 3'($urandom);
      send(o, a, b, d);
      m = model(o, a, b);
      push(d, m[7:0], m[8]);
      if (($urandom & 3) == 0) idle(1);
    end
    idle(2);
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_mul(input logic [7:0] a, input logic [7:0] b, input logic [2:0] d,
                          input logic [7:0] rd, input logic rf);
    send(3'd7, a, b, d);
    push(d, rd, rf);
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || enableWrite !== 1'b0) begin
        failures++;
        $display("FAIL mul_busy cycle=%0d got rdy=%0b busy=%0b en=%0b required 0/1/0", i, in_ready, busy, enableWrite);
      end
      @(negedge clock);
      in_valid = (i < 7); op = 3'd0; regA = 8'hFF; regB = 8'hFF; dest = 3'd6;
      @(posedge clock);
    end
    #1;
    checks++;
    if (enableWrite !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mul_latency got en=%0b rdy=%0b required 1/1", enableWrite, in_ready);
    end
    idle(2);
  endtask

  task automatic test_mul_abort();
    int before;
    send(3'd7, 8'h0D, 8'h0B, 3'd3);
    @(negedge clock); in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({enableWrite, registerWrite, dataIn, flag, busy, in_ready} !== {1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL abort_reset got en=%0b addr=%0d data=%02h flag=%0b busy=%0b rdy=%0b required 0/0/00/0/0/1",
               enableWrite, registerWrite, dataIn, flag, busy, in_ready);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    before = wb_seen;
    repeat (14) @(negedge clock);
    checks++;
    if (wb_seen != before || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_no_wb got pulses=%0d rdy=%0b required 0/1", wb_seen - before, in_ready);
    end
  endtask
`else
  task automatic test_mov();
    send(3'd7, 8'h33, 8'h5A, 3'd2);
    push(3'd2, 8'h5A, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mov_ready got rdy=%0b busy=%0b required 1/0", in_ready, busy);
    end
    send(3'd7, 8'h33, 8'h00, 3'd0);
    push(3'd0, 8'h00, 1'b1);
    idle(2);
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_shift();
`ifdef EXEC_MUL_EN
    test_mul(8'h0D, 8'h0B, 3'd3, 8'h8F, 1'b0);
    test_mul(8'h20, 8'h10, 3'd0, 8'h00, 1'b1);
    test_mul_abort();
`else
    test_mov();
`endif
    test_random();
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_wb got pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running required finished");
    $fatal(1, "timeout");
  end

endmodule
